// File: rtl/reg_group_pkg.sv
// Shared definitions for the banked register group.
// Contents: interrupt context state enum, bank index constants, and the
// default data width and pc reset value used by reg_group_banked.
package reg_group_pkg;

  typedef enum logic [0:0] {
    ST_NORMAL,
    ST_IRQ
  } state_e;

  localparam logic BANK_MAIN   = 1'b0;
  localparam logic BANK_SHADOW = 1'b1;

  localparam int unsigned DATA_W_DEF = 32;
  localparam logic [31:0] PC_RST_DEF = 32'h0001_0000;

endpackage

// File: rtl/reg_group_bank.sv
// One bank of general-purpose registers plus a flag register.
// Ports:
//   clk           clock, all updates on rising edge
//   clr           synchronous clear of every register in the bank
//   wr_en/wr_idx/wr_data   indexed GPR write port; indices >= GprNum are dropped
//   flag_wr_en/flag_wr_data  flag write port
//   gpr_all       flat read bus, register i at bits [i*DataW +: DataW]
//   flag          flag register
module reg_group_bank #(
  parameter int unsigned DataW  = 32,
  parameter int unsigned GprNum = 8
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [3:0]               wr_idx,
  input  logic [DataW-1:0]         wr_data,
  input  logic                     flag_wr_en,
  input  logic [DataW-1:0]         flag_wr_data,
  output logic [GprNum*DataW-1:0]  gpr_all,
  output logic [DataW-1:0]         flag
);

  logic [DataW-1:0] gpr_q [GprNum];
  logic [DataW-1:0] flag_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int unsigned i = 0; i < GprNum; i++) begin
        gpr_q[i] <= '0;
      end
      flag_q <= '0;
    end else begin
      // Out-of-range indices match no register and are silently dropped.
      for (int unsigned i = 0; i < GprNum; i++) begin
        if (wr_en && (32'(wr_idx) == i)) begin
          gpr_q[i] <= wr_data;
        end
      end
      if (flag_wr_en) begin
        flag_q <= flag_wr_data;
      end
    end
  end

  for (genvar g = 0; g < GprNum; g++) begin : g_rd
    assign gpr_all[g*DataW +: DataW] = gpr_q[g];
  end

  assign flag = flag_q;

endmodule

// File: rtl/reg_group_banked.sv
// CPU core register group with interrupt context handling.
// Holds GPR_NUM general registers plus flag (banked), and the unbanked special
// registers pc, tpc, ipc, sp, tlb, sys. A two-state machine (NORMAL/IRQ) handles
// interrupt entry and return; pc and sys are saved/restored around the handler.
// Optional macro REG_GROUP_SHADOW_EN adds a second GPR+flag bank used while in IRQ.
// Ports:
//   clk, all_rst               clock and synchronous active-high reset
//   gpr_all, flag              active-bank GPRs (flat) and flag
//   pc, tpc, ipc, sp, tlb, sys special registers
//   wb_en/wb_idx/wb_data       indexed GPR write-back
//   back_*/back_*_ask          special register writes from write-back
//   loadorder_*                fetch-side pc/tpc/sys writes, pc_stop holds pc
//   interrupt_ask/_pc/_ipc     interrupt entry, iret_ask interrupt return
//   in_irq, irq_nest_err       state and nested-interrupt pulse
//   thisOrderAddress.. / next* pipeline tags delayed by one cycle
module reg_group_banked
  import reg_group_pkg::*;
#(
  parameter int unsigned        DATA_W  = DATA_W_DEF,
  parameter int unsigned        GPR_NUM = 8,
  parameter logic [DATA_W-1:0]  PC_RST  = DATA_W'(PC_RST_DEF)
) (
  input  logic                       clk,
  input  logic                       all_rst,
  output logic [GPR_NUM*DATA_W-1:0]  gpr_all,
  output logic [DATA_W-1:0]          flag,
  output logic [DATA_W-1:0]          pc,
  output logic [DATA_W-1:0]          tpc,
  output logic [DATA_W-1:0]          ipc,
  output logic [DATA_W-1:0]          sp,
  output logic [DATA_W-1:0]          tlb,
  output logic [DATA_W-1:0]          sys,
  input  logic                       wb_en,
  input  logic [3:0]                 wb_idx,
  input  logic [DATA_W-1:0]          wb_data,
  input  logic [DATA_W-1:0]          back_flag,
  input  logic [DATA_W-1:0]          back_tpc,
  input  logic [DATA_W-1:0]          back_ipc,
  input  logic [DATA_W-1:0]          back_sp,
  input  logic [DATA_W-1:0]          back_tlb,
  input  logic                       back_flag_ask,
  input  logic                       back_tpc_ask,
  input  logic                       back_ipc_ask,
  input  logic                       back_sp_ask,
  input  logic                       back_tlb_ask,
  input  logic [DATA_W-1:0]          loadorder_pc,
  input  logic [DATA_W-1:0]          loadorder_tpc,
  input  logic [DATA_W-1:0]          loadorder_sys,
  input  logic                       loadorder_tpc_ask,
  input  logic                       loadorder_sys_ask,
  input  logic                       pc_stop,
  input  logic                       interrupt_ask,
  input  logic [DATA_W-1:0]          interrupt_pc,
  input  logic [DATA_W-1:0]          interrupt_ipc,
  input  logic                       iret_ask,
  output logic                       in_irq,
  output logic                       irq_nest_err,
  input  logic [DATA_W-1:0]          thisOrderAddress,
  output logic [DATA_W-1:0]          nextOrderAddress,
  input  logic                       this_isRunning,
  output logic                       next_isRunning,
  input  logic                       interrupt,
  output logic                       next_interrupt,
  input  logic [7:0]                 interrupt_num,
  output logic [7:0]                 next_interrupt_num
);

  state_e            state_q;
  logic [DATA_W-1:0] pc_q, tpc_q, ipc_q, sp_q, tlb_q, sys_q, sys_save_q;
  logic              nest_err_q;
  logic [DATA_W-1:0] next_addr_q;
  logic              next_run_q, next_int_q;
  logic [7:0]        next_num_q;

  logic irq_entry, irq_return;
  logic gpr_wr_ok, flag_wr_ok;

  assign irq_entry  = (state_q == ST_NORMAL) && interrupt_ask;
  assign irq_return = (state_q == ST_IRQ) && iret_ask;
  // Entry drops every write of that cycle; return still lets GPR/flag land in bank 1.
  assign gpr_wr_ok  = wb_en && !irq_entry;
  assign flag_wr_ok = back_flag_ask && !irq_entry;

`ifdef REG_GROUP_SHADOW_EN
  logic                      active_bank;
  logic [GPR_NUM*DATA_W-1:0] gpr_b0, gpr_b1;
  logic [DATA_W-1:0]         flag_b0, flag_b1;

  // The shadow bank is in use exactly while the state is IRQ.
  assign active_bank = (state_q == ST_IRQ) ? BANK_SHADOW : BANK_MAIN;

  reg_group_bank #(
    .DataW  (DATA_W),
    .GprNum (GPR_NUM)
  ) u_bank0 (
    .clk          (clk),
    .clr          (all_rst),
    .wr_en        (gpr_wr_ok && (active_bank == BANK_MAIN)),
    .wr_idx       (wb_idx),
    .wr_data      (wb_data),
    .flag_wr_en   (flag_wr_ok && (active_bank == BANK_MAIN)),
    .flag_wr_data (back_flag),
    .gpr_all      (gpr_b0),
    .flag         (flag_b0)
  );

  reg_group_bank #(
    .DataW  (DATA_W),
    .GprNum (GPR_NUM)
  ) u_bank1 (
    .clk          (clk),
    .clr          (all_rst),
    .wr_en        (gpr_wr_ok && (active_bank == BANK_SHADOW)),
    .wr_idx       (wb_idx),
    .wr_data      (wb_data),
    .flag_wr_en   (flag_wr_ok && (active_bank == BANK_SHADOW)),
    .flag_wr_data (back_flag),
    .gpr_all      (gpr_b1),
    .flag         (flag_b1)
  );

  assign gpr_all = (active_bank == BANK_SHADOW) ? gpr_b1 : gpr_b0;
  assign flag    = (active_bank == BANK_SHADOW) ? flag_b1 : flag_b0;
`else
  reg_group_bank #(
    .DataW  (DATA_W),
    .GprNum (GPR_NUM)
  ) u_bank0 (
    .clk          (clk),
    .clr          (all_rst),
    .wr_en        (gpr_wr_ok),
    .wr_idx       (wb_idx),
    .wr_data      (wb_data),
    .flag_wr_en   (flag_wr_ok),
    .flag_wr_data (back_flag),
    .gpr_all      (gpr_all),
    .flag         (flag)
  );
`endif

  always_ff @(posedge clk) begin
    if (all_rst) begin
      state_q     <= ST_NORMAL;
      pc_q        <= PC_RST;
      tpc_q       <= '0;
      ipc_q       <= '0;
      sp_q        <= '0;
      tlb_q       <= '0;
      sys_q       <= '0;
      sys_save_q  <= '0;
      nest_err_q  <= 1'b0;
      next_addr_q <= '0;
      next_run_q  <= 1'b0;
      next_int_q  <= 1'b0;
      next_num_q  <= '0;
    end else begin
      nest_err_q  <= (state_q == ST_IRQ) && interrupt_ask;
      next_addr_q <= thisOrderAddress;
      next_run_q  <= this_isRunning;
      next_int_q  <= interrupt;
      next_num_q  <= interrupt_num;

      if (irq_entry) begin
        pc_q       <= interrupt_pc;
        ipc_q      <= interrupt_ipc;
        sys_save_q <= sys_q;
        sys_q      <= '0;
        state_q    <= ST_IRQ;
      end else begin
        if (back_sp_ask)  sp_q  <= back_sp;
        if (back_tlb_ask) tlb_q <= back_tlb;
        if (irq_return) begin
          pc_q    <= ipc_q;
          sys_q   <= sys_save_q;
          state_q <= ST_NORMAL;
        end else begin
          if (back_tpc_ask)           tpc_q <= back_tpc;
          else if (loadorder_tpc_ask) tpc_q <= loadorder_tpc;
          if (back_ipc_ask)           ipc_q <= back_ipc;
          if (loadorder_sys_ask)      sys_q <= loadorder_sys;
          if (!pc_stop)               pc_q  <= loadorder_pc;
        end
      end
    end
  end

  assign pc                 = pc_q;
  assign tpc                = tpc_q;
  assign ipc                = ipc_q;
  assign sp                 = sp_q;
  assign tlb                = tlb_q;
  assign sys                = sys_q;
  assign in_irq             = (state_q == ST_IRQ);
  assign irq_nest_err       = nest_err_q;
  assign nextOrderAddress   = next_addr_q;
  assign next_isRunning     = next_run_q;
  assign next_interrupt     = next_int_q;
  assign next_interrupt_num = next_num_q;

endmodule
